// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, state enum and small-sigma functions
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_BLOCK = 64;
  typedef enum logic {IDLE, EXPAND} state_t;
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/message_schedule.sv
// message_schedule: expands a 512-bit padded block into SHA-256 words W0..W63, one per cycle
module message_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_rst,
  input  logic [511:0]      data_in,
  input  logic              data_in_last,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [WORD_W-1:0] data_out,
  output logic [5:0]        data_out_index,
  output logic              data_out_block_last,
  output logic              data_out_last,
  output logic              data_out_valid,
  input  logic              data_out_ready
);
  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_window [16];
  logic [5:0]        r_t;
  logic              r_last;
  logic              w_expand, w_end, w_out_hs, w_in_hs;
  logic [WORD_W-1:0] w_new;
  assign w_expand = r_state == EXPAND;
  assign w_end = r_t == 6'(WORDS_PER_BLOCK - 1);
  assign w_out_hs = w_expand & data_out_ready;
  assign data_in_ready = ~w_expand | (w_end & data_out_ready);
  assign w_in_hs = data_in_valid & data_in_ready;
  // window[15] after the shift holds W(t+16)
  assign w_new = sigma1(r_window[14]) + r_window[9] + sigma0(r_window[1]) + r_window[0];
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_in_hs ? EXPAND : (w_out_hs & w_end) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else if (sync_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
      r_t <= '0;
      r_last <= 1'b0;
    end else if (sync_rst) begin
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
      r_t <= '0;
      r_last <= 1'b0;
    end else if (w_in_hs) begin
      for (int i = 0; i < 16; i++) r_window[i] <= data_in[511-32*i -: 32];
      r_t <= '0;
      r_last <= data_in_last;
    end else if (w_out_hs & ~w_end) begin
      for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
      r_window[15] <= w_new;
      r_t <= r_t + 6'd1;
    end
  end
  assign data_out = w_expand ? r_window[0] : '0;
  assign data_out_valid = w_expand;
  assign data_out_index = w_expand ? r_t : '0;
  assign data_out_block_last = w_expand & w_end;
  assign data_out_last = w_expand & w_end & r_last;
endmodule

// File: tb/tb_message_schedule.sv
// tb_message_schedule: scoreboard bench with a software SHA-256 schedule model
module tb_message_schedule;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync_rst = 1'b0;
  logic [511:0] data_in = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [31:0]  data_out;
  logic [5:0]   data_out_index;
  logic         data_out_block_last;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;

  message_schedule dut (
    .clk(clk), .rst(rst), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_index(data_out_index),
    .data_out_block_last(data_out_block_last), .data_out_last(data_out_last),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  idx;
    logic        bl;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic push_block(input logic [511:0] blk, input logic last);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) q.push_back(exp_t'{w[t], 6'(t), t == 63, (t == 63) && last});
  endtask

  always @(posedge clk) begin
    #1;
    data_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [5:0]  prev_i;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!data_out_valid) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_data", data_out, prev_d);
        chk("stall_index", data_out_index, prev_i);
      end
      if (data_out_index != 6'd63) chk("early_in_ready", data_in_ready, 0);
      if (data_out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h idx %0d with empty scoreboard", data_out, data_out_index);
        end else begin
          mon_e = q.pop_front();
          chk("word", data_out, mon_e.d);
          chk("index", data_out_index, mon_e.idx);
          chk("block_last", data_out_block_last, mon_e.bl);
          chk("last", data_out_last, mon_e.l);
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_d = data_out;
        prev_i = data_out_index;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge, valid left high
  task automatic send_block(input logic [511:0] blk, input logic last);
    int n = 0;
    data_in = blk;
    data_in_last = last;
    data_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (data_in_ready) break;
      if (++n > 3000) begin
        fail_now("send_block");
        break;
      end
    end
    if (n <= 3000) begin
      if (data_out_valid) chk("accept_at_63", data_out_index, 63);
      push_block(blk, last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_index(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(data_out_valid && data_out_index == 6'(k)) && n < 3000);
    if (n >= 3000) fail_now("wait_index");
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || data_out_valid) && n < 3000);
    if (n >= 3000) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc;
    logic [511:0] blk;
    logic [31:0]  cap [18];
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0] = 32'h00000018;
    repeat (2) @(negedge clk);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_index", data_out_index, 0);
    chk("rst_block_last", data_out_block_last, 0);
    chk("rst_last", data_out_last, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", data_in_ready, 1);
    @(posedge clk);
    #1;
    send_block(abc, 1'b1);
    data_in_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("latency_valid", data_out_valid, 1);
        chk("latency_index", data_out_index, 0);
      end
      cap[i] = data_out;
    end
    chk("abc_w0", cap[0], 64'h61626380);
    chk("abc_w1", cap[1], 64'h0);
    chk("abc_w14", cap[14], 64'h0);
    chk("abc_w15", cap[15], 64'h18);
    chk("abc_w16", cap[16], 64'h61626380);
    chk("abc_w17", cap[17], 64'h000F0000);
    drain();
    send_block(rand_block(), 1'b0);
    send_block(rand_block(), 1'b1);
    @(negedge clk);
    chk("b2b_valid", data_out_valid, 1);
    chk("b2b_index", data_out_index, 0);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    drain();
    rnd_ready = 1'b1;
    for (int b = 0; b < 3; b++) send_block(rand_block(), 1'($urandom_range(0, 1)));
    data_in_valid = 1'b0;
    drain();
    send_block(rand_block(), 1'b0);
    data_in_valid = 1'b0;
    wait_index(20);
    @(posedge clk);
    #1;
    blk = rand_block();
    data_in = blk;
    data_in_last = 1'b1;
    data_in_valid = 1'b1;
    @(negedge clk);
    chk("mid_block_ready", data_in_ready, 0);
    @(posedge clk);
    #1;
    send_block(blk, 1'b1);
    data_in_valid = 1'b0;
    drain();
    send_block(rand_block(), 1'b1);
    data_in_valid = 1'b0;
    wait_index(30);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", data_out_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_index", data_out_index, 0);
    chk("arst_last", data_out_last, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", data_in_ready, 1);
    @(posedge clk);
    #1;
    send_block(rand_block(), 1'b0);
    data_in_valid = 1'b0;
    drain();
    send_block(rand_block(), 1'b1);
    data_in_valid = 1'b0;
    wait_index(40);
    @(posedge clk);
    #1 sync_rst = 1'b1;
    @(negedge clk);
    chk("srst_not_yet", data_out_valid, 1);
    @(posedge clk);
    #1 sync_rst = 1'b0;
    chk("srst_valid", data_out_valid, 0);
    chk("srst_data", data_out, 0);
    chk("srst_index", data_out_index, 0);
    chk("srst_in_ready", data_in_ready, 1);
    q.delete();
    send_block(rand_block(), 1'b1);
    data_in_valid = 1'b0;
    drain();
    rnd_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/message_schedule.md
# message_schedule

Expands each 512-bit padded message block into the 64 32-bit schedule words W0..W63 of SHA-256. Emits them one word per cycle to the compression stage. Sits directly downstream of the message builder and consumes its 512-bit padded block stream, including the message-last flag. Implements a 16-word sliding window, a 6-bit word counter, and valid/ready handshakes on both sides.

## Interface
- No parameters. Word width is 32 and words per block is 64; both are fixed constants from the package.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- sync_rst  in  1  synchronous localised reset; same effect as rst, applied at the next rising edge.
- data_in  in  512  padded block. Big-endian words: W0 = data_in[511:480], W15 = data_in[31:0].
- data_in_last  in  1  block is the final block of its message.
- data_in_valid  in  1  upstream block valid.
- data_in_ready  out  1  block accepted when valid & ready.
- data_out  out  32  current schedule word Wt.
- data_out_index  out  6  t of the current word, 0..63.
- data_out_block_last  out  1  high when t == 63.
- data_out_last  out  1  high when t == 63 and the block had data_in_last set.
- data_out_valid  out  1  data_out is valid.
- data_out_ready  in  1  downstream accepts the word when valid & ready.

## Operation
- Reset (rst or sync_rst) values:
  - state IDLE, window all 0, t = 0, last_reg 0.
  - data_out 0, data_out_index 0, data_out_valid 0, data_out_block_last 0, data_out_last 0.
  - data_in_ready reads 1 once reset is released.
- States:
  - IDLE: no block loaded.
  - EXPAND: a block is loaded and words are being emitted.
- data_in_ready is combinational: (state == IDLE) | (state == EXPAND & t == 63 & data_out_ready).
- Input handshake:
  - Load window[i] = Wi for i = 0..15.
  - Set t = 0 and last_reg = data_in_last.
  - Go to (or stay in) EXPAND.
- In EXPAND:
  - data_out = window[0], data_out_valid = 1, data_out_index = t.
  - data_out_block_last = (t == 63); data_out_last = (t == 63) & last_reg.
- Output handshake with t < 63:
  - window[i] <= window[i+1] for i = 0..14.
  - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
  - t <= t + 1.
- Output handshake with t == 63:
  - If data_in_valid in the same cycle, load the new block (back-to-back; no bubble).
  - Otherwise return to IDLE, with data_out_valid falling on the next cycle.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- The adder wraps at 32 bits and the carry out is discarded.
- Stall (data_out_valid & !data_out_ready):
  - Window, t and all outputs hold stable.
  - data_in_ready stays 0 while t < 63.
- data_in_valid while in EXPAND with t < 63 is ignored (not accepted).
- A reset mid-block discards the block. No partial output is flushed; valid drops immediately under async rst, or at the next edge under sync_rst.

## Timing
- Latency: input handshake in cycle N gives W0 valid in cycle N+1.
- Throughput: 64 cycles per block with data_out_ready held high. A continuous stream needs no idle cycles between blocks.
- Computing W16..W63 adds no latency beyond one register stage.
- All outputs are registered except data_in_ready.

## Structure
- Shared package sha256_pkg holds:
  - word width (32) and words-per-block (64) constants;
  - sigma0/sigma1 functions (later reused by compression as big-sigma siblings);
  - the state enum {IDLE, EXPAND}.
- Single module with no sub-module. The expansion adder is inline combinational logic.

## Test plan
- "abc" block (data_in = 0x61626380 followed by zeros, with the low word 0x00000018), last = 1, ready held high:
  - W0 = 0x61626380, W1..W14 = 0, W15 = 0x18, W16 = 0x61626380, W17 = 0x000F0000.
  - data_out_last high only at t = 63.
- Two blocks back-to-back, second valid held high:
  - Second block is accepted in the same cycle as W63 of the first.
  - The W0 of block 2 follows immediately, with no gap.
  - data_out_last set only on block 2.
- Random data_out_ready (50% duty):
  - All 64 words match the software model, in order.
  - data_out is stable while stalled.
  - No input is accepted before t = 63.
- data_in_valid asserted mid-block (t = 20):
  - data_in_ready = 0 and the block is not consumed.
  - It is accepted at the t = 63 handshake.
- rst pulsed at t = 30:
  - Outputs go to their reset values asynchronously.
  - After release, data_in_ready = 1 and a new block restarts at W0.
- sync_rst at t = 40:
  - Reset values appear at the next edge; the next block produces correct W0..W63.
